// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready handshakes.
// Stage 1 precomputes per-block sums for both carry-ins; stage 2 resolves the select chain.
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLK;

    // Block 0 lives in the carry-in-0 vectors and holds the true sum/carry.
    logic [WIDTH-1:0]   w_sum0;
    logic [WIDTH-1:BLK] w_sum1;
    logic [NBLK-1:0]    w_c0;
    logic [NBLK-1:1]    w_c1;

    logic [WIDTH-1:0]   r_sum0;
    logic [WIDTH-1:BLK] r_sum1;
    logic [NBLK-1:0]    r_c0;
    logic [NBLK-1:1]    r_c1;
    logic               r_s1_valid;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_out_valid;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_in_fire;
    logic [WIDTH-1:0]   w_sel_sum;
    logic               w_sel_cout;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_in_fire = in_valid && w_s1_adv;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

    assign {w_c0[0], w_sum0[BLK-1:0]} =
        {1'b0, a[BLK-1:0]} + {1'b0, b[BLK-1:0]} + {{BLK{1'b0}}, cin};

    for (genvar k = 1; k < NBLK; k++) begin : g_blk
        assign {w_c0[k], w_sum0[k*BLK +: BLK]} =
            {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]};
        assign {w_c1[k], w_sum1[k*BLK +: BLK]} =
            {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
    end

    // NOTE: every output of a combinational block gets a value before any branch, so no latch is inferred.
    always_comb begin : p_select
        logic v_c;
        w_sel_sum            = '0;
        v_c                  = r_c0[0];
        w_sel_sum[BLK-1:0]   = r_sum0[BLK-1:0];
        for (int k = 1; k < NBLK; k++) begin
            w_sel_sum[k*BLK +: BLK] = v_c ? r_sum1[k*BLK +: BLK] : r_sum0[k*BLK +: BLK];
            v_c                     = v_c ? r_c1[k] : r_c0[k];
        end
        w_sel_cout = v_c;
    end

    // NOTE: registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_sum0     <= '0;
            r_sum1     <= '0;
            r_c0       <= '0;
            r_c1       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_sum0 <= w_sum0;
                r_sum1 <= w_sum1;
                r_c0   <= w_c0;
                r_c1   <= w_c1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sel_sum;
                r_cout <= w_sel_cout;
            end
        end
    end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Self-checking bench for csel_adder_pipe: directed, random and parameter-sweep traffic
// compared against a queue-based reference of a+b+cin with two-cycle latency.
module tb_csel_adder_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;

    logic        iv32, ir32, cin32, ov32, cout32;
    logic [31:0] a32, b32, sum32;
    logic        iv8, ir8, cin8, ov8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        or_sweep;

    int n_cmp;
    int n_err;
    int cyc;

    typedef struct {
        logic [16:0] res;
        int          acc;
    } item_t;

    item_t       q16[$];
    logic [32:0] q32[$];
    logic [8:0]  q8[$];

    csel_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    csel_adder_pipe #(.WIDTH(32), .BLK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(or_sweep),
        .sum(sum32), .cout(cout32)
    );

    csel_adder_pipe #(.WIDTH(8), .BLK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or_sweep),
        .sum(sum8), .cout(cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: each accepted operand pair becomes a+b+cin, visible two cycles after
    // the cycle it was accepted in, leaving in order; the pipe holds at most two.
    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
        end else begin
            logic exp_ov;
            cyc++;
            exp_ov = (q16.size() > 0) && (cyc >= q16[0].acc + 2);
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("in_ready", 64'(in_ready), 64'(!(q16.size() == 2 && !out_ready)));
            if (out_valid && exp_ov) begin
                check("sum", 64'(sum), 64'(q16[0].res[15:0]));
                check("cout", 64'(cout), 64'(q16[0].res[16]));
                if (out_ready) void'(q16.pop_front());
            end
            if (in_valid && in_ready) begin
                item_t it;
                it.res = {1'b0, a} + {1'b0, b} + 17'(cin);
                it.acc = cyc;
                q16.push_back(it);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            q8.delete();
        end else begin
            if (ov32) begin
                if (q32.size() > 0) begin
                    check("w32_result", 64'({cout32, sum32}), 64'(q32[0]));
                    void'(q32.pop_front());
                end else begin
                    check("w32_spurious", 64'(q32.size()), 64'(1));
                end
            end
            if (iv32) begin
                check("w32_in_ready", 64'(ir32), 64'(1));
                if (ir32) q32.push_back({1'b0, a32} + {1'b0, b32} + 33'(cin32));
            end
            if (ov8) begin
                if (q8.size() > 0) begin
                    check("w8_result", 64'({cout8, sum8}), 64'(q8[0]));
                    void'(q8.pop_front());
                end else begin
                    check("w8_spurious", 64'(q8.size()), 64'(1));
                end
            end
            if (iv8) begin
                check("w8_in_ready", 64'(ir8), 64'(1));
                if (ir8) q8.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
            end
        end
    end

    // Presents one operand set and holds it until accepted; returns #1 after the accepting edge.
    task automatic push(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_c);
        int budget;
        budget   = 100;
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        cin      = op_c;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        check("push_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        iv8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
        or_sweep = 1'b1;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rel_in_ready", 64'(in_ready), 64'(1));
        idle(2);

        // Basic add and full-ripple cases, spaced out so each latency is seen alone.
        push(16'h1234, 16'h4321, 1'b1);
        idle(3);
        push(16'hFFFF, 16'h0001, 1'b0);
        push(16'hFFFF, 16'hFFFF, 1'b1);
        push(16'h0FFF, 16'h0000, 1'b1);
        idle(4);

        // Back-to-back streaming.
        for (int i = 0; i < 8; i++) push(16'($urandom), 16'($urandom), 1'($urandom));
        idle(4);

        // Backpressure: two results fill the pipe, third waits until release.
        out_ready = 1'b0;
        push(16'h0001, 16'h0001, 1'b0);
        push(16'h00FF, 16'h0001, 1'b0);
        fork
            push(16'h1000, 16'h1000, 1'b0);
            begin
                idle(5);
                check("bp_held_sum", 64'(sum), 64'(16'h0002));
                out_ready = 1'b1;
            end
        join
        idle(5);

        // Reset asserted between edges with two operations in flight.
        push(16'h1111, 16'h2222, 1'b0);
        push(16'h3333, 16'h4444, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_sum", 64'(sum), 64'(0));
        check("mid_rst_cout", 64'(cout), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("mid_rel_in_ready", 64'(in_ready), 64'(1));
        idle(5);

        // Random valid/ready traffic on the 16-bit instance.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            idle(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(5);

        // Parameter sweep: 1000 streamed vectors on each alternate geometry.
        for (int i = 0; i < 1000; i++) begin
            iv32 = 1'b1; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            iv8  = 1'b1; a8  = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            if (i % 50 == 0) begin
                a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1;
                a8  = 8'hFF;         b8  = 8'h0;  cin8  = 1'b1;
            end
            idle(1);
        end
        iv32 = 1'b0;
        iv8  = 1'b0;
        idle(5);

        check("q16_drained", 64'(q16.size()), 64'(0));
        check("q32_drained", 64'(q32.size()), 64'(0));
        check("q8_drained", 64'(q8.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
